// File: rtl/dem_pkg.sv
// Shared constants, state encoding and code saturation for the DEM vector quantizer.
package dem_pkg;

  localparam int N_ELEM = 6;
  localparam int W_SFM  = 6;
  localparam logic [2:0] MAX_CODE = 3'd6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic logic [2:0] sat_code(input logic [2:0] c);
    return (c > MAX_CODE) ? MAX_CODE : c;
  endfunction

endpackage

// File: rtl/max6_vq.sv
// Combinational argmax over six unmasked shaping values; one-hot result, lowest index wins ties.
module max6_vq
  import dem_pkg::*;
(
  input  logic [N_ELEM-1:0][W_SFM-1:0] i_val,
  input  logic [N_ELEM-1:0]            i_mask,
  output logic [N_ELEM-1:0]            o_win
);

  logic             w_found;
  logic [W_SFM-1:0] w_best;

  // Strict '>' keeps the earlier (lower) index on equal values.
  always_comb begin
    w_found = 1'b0;
    w_best  = '0;
    o_win   = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      if (!i_mask[i] && (!w_found || (i_val[i] > w_best))) begin
        w_found  = 1'b1;
        w_best   = i_val[i];
        o_win    = '0;
        o_win[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dem_vq6_seq.sv
// Sequential 6-element DEM vector quantizer: one element selected per clk until sat(code) are on.
//
// state  | meaning
// IDLE   | waiting for a sample, in_ready high
// SEARCH | selecting one element per edge, in_ready low
// DONE   | sv just updated, sv_valid high, may accept the next sample
module dem_vq6_seq
  import dem_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic [2:0]         i_code,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [W_SFM-1:0]   i_sfm0,
  input  logic [W_SFM-1:0]   i_sfm1,
  input  logic [W_SFM-1:0]   i_sfm2,
  input  logic [W_SFM-1:0]   i_sfm3,
  input  logic [W_SFM-1:0]   i_sfm4,
  input  logic [W_SFM-1:0]   i_sfm5,
  output logic [N_ELEM-1:0]  o_sv,
  output logic               o_sv_valid
);

  state_t                      r_state;
  state_t                      w_next;
  logic [N_ELEM-1:0][W_SFM-1:0] r_sfm;
  logic [N_ELEM-1:0]           r_mask;
  logic [2:0]                  r_cnt;
  logic [N_ELEM-1:0]           r_sv;
  logic                        r_sv_valid;
  logic [N_ELEM-1:0]           w_win;
  logic                        w_accept;
  logic                        w_in_ready;

  max6_vq u_max6_vq (
    .i_val  (r_sfm),
    .i_mask (r_mask),
    .o_win  (w_win)
  );

  assign w_accept = i_in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // cnt of 1 means the selection made on this edge is the last one.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = SEARCH;
      SEARCH:  if (r_cnt <= 3'd1) w_next = DONE;
      DONE:    w_next = w_accept ? SEARCH : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_in_ready = (r_state == IDLE) || (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sfm      <= '0;
      r_mask     <= '0;
      r_cnt      <= '0;
      r_sv       <= '0;
      r_sv_valid <= 1'b0;
    end else begin
      r_sv_valid <= 1'b0;
      if (w_accept) begin
        r_sfm  <= {i_sfm5, i_sfm4, i_sfm3, i_sfm2, i_sfm1, i_sfm0};
        r_cnt  <= sat_code(i_code);
        r_mask <= '0;
      end else if (r_state == SEARCH) begin
        if (r_cnt != 3'd0) begin
          r_mask <= r_mask | w_win;
          r_cnt  <= r_cnt - 3'd1;
        end
        if (r_cnt <= 3'd1) begin
          r_sv       <= (r_cnt != 3'd0) ? (r_mask | w_win) : r_mask;
          r_sv_valid <= 1'b1;
        end
      end
    end
  end

  assign o_in_ready = w_in_ready;
  assign o_sv       = r_sv;
  assign o_sv_valid = r_sv_valid;

endmodule
